// File: rtl/rot_count_seq.sv
// Sequencer for the 16-bit rotate-right path: breaks an 8-bit count into
// steps of at most STEP_MAX, feeds the external rotate mux, and registers result/CF/OF.
module rot_count_seq #(
  parameter int unsigned STEP_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] operand,
  input  logic [7:0]  count,
  output logic [15:0] rot_a,
  output logic [3:0]  rot_op,
  input  logic [15:0] rot_r,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        cf,
  output logic        of
);

  localparam int unsigned DW  = 16;
  localparam int unsigned CW  = 8;
  localparam int unsigned OPW = 4;
  localparam logic [OPW-1:0] STEP_CAP = OPW'(STEP_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [DW-1:0]   result_q, result_d;
  logic            cf_q, cf_d;
  logic            of_q, of_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [OPW-1:0]  step_c;
  logic [CW-1:0]   rem_left_c;

  // Per-cycle rotate amount: whatever remains, capped at STEP_MAX.
  always_comb begin
    step_c     = (rem_q < CW'(STEP_MAX)) ? rem_q[OPW-1:0] : STEP_CAP;
    rem_left_c = rem_q - CW'(step_c);
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    cf_d     = cf_q;
    of_d     = of_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = operand;
          rem_d = count;
          if (count != '0) begin
            state_d = S_ROT;
          end else begin
            // Zero count: value passes through, flags left untouched.
            state_d  = S_DONE;
            result_d = operand;
          end
        end
      end
      S_ROT: begin
        acc_d = rot_r;
        rem_d = rem_left_c;
        if (rem_left_c == '0) begin
          state_d  = S_DONE;
          result_d = rot_r;
          cf_d     = rot_r[DW-1];
          of_d     = rot_r[DW-1] ^ rot_r[DW-2];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      cf_q     <= 1'b0;
      of_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      cf_q     <= cf_d;
      of_q     <= of_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The mux sees the accumulator directly and only rotates while stepping.
  assign rot_a  = acc_q;
  assign rot_op = (state_q == S_ROT) ? step_c : '0;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cf     = cf_q;
  assign of     = of_q;

endmodule

// File: tb/tb_rot_count_seq.sv
// Directed bench for rot_count_seq: STEP_MAX=15 and STEP_MAX=1 instances,
// each wired to a behavioural rotate-right mux.
module tb_rot_count_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [15:0] operand = '0;
  logic [7:0]  count = '0;
  logic        sel = 1'b0;

  logic [15:0] rot_a_a, rot_r_a, result_a;
  logic [3:0]  rot_op_a;
  logic        busy_a, done_a, cf_a, of_a;
  logic [15:0] rot_a_b, rot_r_b, result_b;
  logic [3:0]  rot_op_b;
  logic        busy_b, done_b, cf_b, of_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign rot_r_a = 16'({rot_a_a, rot_a_a} >> rot_op_a);
  assign rot_r_b = 16'({rot_a_b, rot_a_b} >> rot_op_b);

  rot_count_seq #(.STEP_MAX(15)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .operand(operand), .count(count),
    .rot_a(rot_a_a), .rot_op(rot_op_a), .rot_r(rot_r_a), .busy(busy_a),
    .done(done_a), .result(result_a), .cf(cf_a), .of(of_a)
  );

  rot_count_seq #(.STEP_MAX(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .operand(operand), .count(count),
    .rot_a(rot_a_b), .rot_op(rot_op_b), .rot_r(rot_r_b), .busy(busy_b),
    .done(done_b), .result(result_b), .cf(cf_b), .of(of_b)
  );

  logic [15:0] result_s;
  logic [3:0]  rot_op_s;
  logic        busy_s, done_s, cf_s, of_s;
  assign result_s = sel ? result_b : result_a;
  assign rot_op_s = sel ? rot_op_b : rot_op_a;
  assign busy_s   = sel ? busy_b   : busy_a;
  assign done_s   = sel ? done_b   : done_a;
  assign cf_s     = sel ? cf_b     : cf_a;
  assign of_s     = sel ? of_b     : of_a;

  typedef struct {
    logic [15:0] opnd;
    logic [7:0]  cnt;
    logic [15:0] res;
    logic        cf;
    logic        of;
    int          cyc;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) start_b = v;
    else   start_a = v;
  endtask

  // One operation: start, per-cycle rot_op checks, completion timing and values.
  task automatic run_op(input bit s, input logic [15:0] opnd, input logic [7:0] cnt,
                        input logic [15:0] er, input logic ecf, input logic eof,
                        input int ecyc, input int step_max, input bit poke);
    int cyc;
    int rem;
    logic [3:0] eop;
    bit seen;
    sel = s;
    @(negedge clk);
    operand = opnd;
    count   = cnt;
    set_start(s, 1'b1);
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    set_start(s, 1'b0);
    operand = 16'hDEAD;
    count   = 8'h5A;
    rem  = int'(cnt);
    seen = 1'b0;
    while (cyc < 300) begin
      if (done_s) begin
        seen = 1'b1;
        break;
      end
      eop = (rem < step_max) ? 4'(rem) : 4'(step_max);
      chk("rot_op_step", 32'(rot_op_s), 32'(eop));
      chk("busy_in_rot", 32'(busy_s), 32'd1);
      rem -= int'(eop);
      if (poke && cyc == 5) begin
        operand = 16'h0F0F;
        count   = 8'd3;
        set_start(s, 1'b1);
      end else begin
        set_start(s, 1'b0);
      end
      @(negedge clk);
      cyc++;
    end
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    chk("done_latency", 32'(cyc), 32'(ecyc));
    chk("steps_total", 32'(rem), 32'd0);
    chk("result", 32'(result_s), 32'(er));
    chk("cf", 32'(cf_s), 32'(ecf));
    chk("of", 32'(of_s), 32'(eof));
    chk("busy_in_done", 32'(busy_s), 32'd1);
    chk("rot_op_in_done", 32'(rot_op_s), 32'd0);
    if (poke) begin
      operand = 16'h1111;
      count   = 8'd1;
      set_start(s, 1'b1);
    end
    @(negedge clk);
    set_start(s, 1'b0);
    chk("done_one_cycle", 32'(done_s), 32'd0);
    chk("idle_after_done", 32'(busy_s), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{16'h1234, 8'd4,   16'h4123, 1'b0, 1'b1, 2};
    vecs[1]  = '{16'h0001, 8'd1,   16'h8000, 1'b1, 1'b1, 2};
    vecs[2]  = '{16'hABCD, 8'd0,   16'hABCD, 1'b1, 1'b1, 1};
    vecs[3]  = '{16'h8001, 8'd40,  16'h0180, 1'b0, 1'b0, 4};
    vecs[4]  = '{16'h1234, 8'd4,   16'h4123, 1'b0, 1'b1, 2};
    vecs[5]  = '{16'hFFFF, 8'd0,   16'hFFFF, 1'b0, 1'b1, 1};
    vecs[6]  = '{16'h1234, 8'd16,  16'h1234, 1'b0, 1'b0, 3};
    vecs[7]  = '{16'h00F0, 8'd15,  16'h01E0, 1'b0, 1'b0, 2};
    vecs[8]  = '{16'hC000, 8'd255, 16'h8001, 1'b1, 1'b1, 18};
    vecs[9]  = '{16'h8000, 8'd30,  16'h0002, 1'b0, 1'b0, 3};
    vecs[10] = '{16'h0003, 8'd2,   16'hC000, 1'b1, 1'b0, 2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rot_a",  32'(rot_a_a),  32'd0);
    chk("rst_rot_op", 32'(rot_op_a), 32'd0);
    chk("rst_busy",   32'(busy_a),   32'd0);
    chk("rst_done",   32'(done_a),   32'd0);
    chk("rst_result", 32'(result_a), 32'd0);
    chk("rst_cf_of",  32'({cf_a, of_a, cf_b, of_b}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(1'b0, vecs[i].opnd, vecs[i].cnt, vecs[i].res, vecs[i].cf, vecs[i].of,
             vecs[i].cyc, 15, 1'b0);
    end

    // Bit-serial instance: long run with a stray start mid-run and in DONE.
    run_op(1'b1, 16'h8000, 8'd255, 16'h0001, 1'b0, 1'b0, 256, 1, 1'b1);
    run_op(1'b1, 16'h0006, 8'd3,   16'hC000, 1'b1, 1'b0, 4,   1, 1'b0);

    // Async reset in the second ROT cycle of a 40-count run.
    sel = 1'b0;
    @(negedge clk);
    operand = 16'h8001;
    count   = 8'd40;
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    chk("pre_rst_rot_op", 32'(rot_op_a), 32'd15);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_rot_a",  32'(rot_a_a),  32'd0);
    chk("abort_rot_op", 32'(rot_op_a), 32'd0);
    chk("abort_busy",   32'(busy_a),   32'd0);
    chk("abort_done",   32'(done_a),   32'd0);
    chk("abort_result", 32'(result_a), 32'd0);
    chk("abort_cf_of",  32'({cf_a, of_a}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int done_seen;
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (done_a || busy_a) done_seen++;
      end
      chk("abort_no_done", 32'(done_seen), 32'd0);
    end
    run_op(1'b0, 16'h1234, 8'd4, 16'h4123, 1'b0, 1'b1, 2, 15, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rot_count_seq.md
Name: rot_count_seq

Overview:
- Sequential controller for the ALU's 16-bit rotate-right path (ROR r/m16, CL).
- Sits directly upstream of the combinational 16-bit rotate-right mux (operand A, 4-bit amount OP, result R). Drives A/OP each cycle and consumes R.
- Splits an 8-bit rotate count into per-cycle steps of at most STEP_MAX bits. Registers the final result and produces CF/OF.

Parameters:
- STEP_MAX, 15, max bits rotated per cycle. Legal range 1..15; 1 gives bit-serial 8088-style timing.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- operand  in  16  value to rotate; sampled with start
- count  in  8  rotate count (0..255), unmasked; sampled with start
- rot_a  out  16  operand to rotate mux (A)
- rot_op  out  4  rotate amount to mux (OP)
- rot_r  in  16  rotated value from mux (R)
- busy  out  1  high in ROT and DONE
- done  out  1  one-cycle completion pulse
- result  out  16  registered final value, held until next completion
- cf  out  1  carry flag
- of  out  1  overflow flag

Behaviour:
- Reset (async, rst=1): state=IDLE; acc=0, rem=0, result=0, cf=0, of=0, busy=0, done=0. Consequently rot_a=0 and rot_op=0.
- A reset asserted mid-operation aborts it: no done pulse, flags cleared.
- Internal registers: acc[15:0], rem[7:0]. rot_a = acc at all times (combinational). rot_op = step in ROT, 0 otherwise.
- step = min(rem, STEP_MAX), 4 bits.
- IDLE:
  - start=1 at an edge: acc<=operand, rem<=count.
  - If count!=0, go to ROT; otherwise go to DONE with the zero-count flag set.
  - busy=0.
- ROT:
  - Each edge: acc<=rot_r, rem<=rem-step.
  - When rem-step==0, go to DONE. At that edge: result<=rot_r, cf<=rot_r[15], of<=rot_r[15]^rot_r[14].
  - Otherwise stay in ROT.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then go to IDLE.
  - Zero-count case: result<=operand at entry; cf and of hold their previous values (8086 semantics: flags untouched).
- start is ignored in ROT and DONE. There is no queueing, and a start in the DONE cycle is dropped.
- Latency:
  - Start accepted at edge N, k = ceil(count/STEP_MAX).
  - ROT occupies cycles N+1..N+k; done is high in cycle N+k+1; result and flags are valid from that cycle.
  - count=0: done in cycle N+1.
- Arithmetic: net rotation equals count mod 16, but the sequence is always stepped; no mod-16 shortcut. This preserves deterministic timing per count.
- OF is defined by the formula above for every nonzero count; the count==1 case matches 8086.
- rot_r is assumed settled within the same cycle; the mux is combinational and in the same clock domain.
- operand and count are don't-care outside the start-accept cycle.

Test Plan:
- STEP_MAX=15, start with operand=0x1234, count=4 -> rot_op=4 for one cycle; done in cycle 2 after start; result=0x4123, cf=0, of=1.
- STEP_MAX=15, operand=0x0001, count=1 -> result=0x8000, cf=1, of=1; done 2 cycles after start.
- STEP_MAX=15, operand=0x8001, count=40 -> rot_op sequence 15,15,10 across 3 ROT cycles; done on the 4th cycle; result=0x0180, cf=0, of=0.
- Preload cf=1, of=1 via a prior operation. Then operand=0xABCD, count=0 -> done next cycle, result=0xABCD, cf=1, of=1 unchanged; rot_op stays 0.
- STEP_MAX=1, operand=0x8000, count=255 -> 255 ROT cycles each with rot_op=1; result=0x0001, cf=0, of=0. A start pulsed mid-run is ignored.
- STEP_MAX=15, count=40: assert rst during the 2nd ROT cycle -> all outputs 0 immediately, no done pulse. After rst drops, a new start with 0x1234/4 completes normally with 0x4123.
